regfile_arbiter: RTL
====================

REGFILE_ARBITER -- requirements
Module: regfile_arbiter

Interface
REQ-001 Parameter DBG_PRIORITY, default 0, selects debug arbitration: 0 = round-robin with CPU, 1 = debug always wins.
REQ-002 Parameter RESET_LAST_DBG, default 1, sets the initial round-robin state: 1 = debug treated as last winner, so CPU wins the first tie.
REQ-003 clk  in  1  single clock; all state updates on its rising edge.
REQ-004 rst_n  in  1  asynchronous, active-low reset.
REQ-005 cpu_req  in  1  CPU write request; held with data stable until cpu_gnt.
REQ-006 cpu_addr  in  5  CPU target register.
REQ-007 cpu_wdata  in  16  CPU write data; only bits [7:0] are used for byte writes.
REQ-008 cpu_word  in  1  1 = 16-bit pair write (MOVW/ADIW), 0 = byte write.
REQ-009 cpu_gnt  out  1  one-cycle pulse when the CPU write is complete.
REQ-010 dbg_req  in  1  debugger request; held with fields stable until dbg_ack.
REQ-011 dbg_we  in  1  1 = debugger write, 0 = debugger read.
REQ-012 dbg_addr  in  5  debugger target register.
REQ-013 dbg_wdata  in  8  debugger write data.
REQ-014 dbg_ack  out  1  one-cycle pulse when the debugger access completes.
REQ-015 dbg_rdata  out  8  read data, valid while dbg_ack=1 for a read; 0 at all other times.
REQ-016 rf_we  out  1  register-file write enable.
REQ-017 rf_addr  out  5  register-file port-1 address, used for both write and read.
REQ-018 rf_wdata  out  8  register-file write data.
REQ-019 rf_rdata  in  8  register-file port-1 combinational read data.

Function
REQ-020 The FSM states SHALL be IDLE, CPU_LO, CPU_HI, DBG_WR and DBG_RD; rf_we, rf_addr, rf_wdata, cpu_gnt and dbg_ack SHALL be registered.
REQ-021 A request is accepted at the rising edge that ends IDLE or the final cycle of an access, giving a throughput of one register access per cycle.
REQ-022 The requester granted in a cycle SHALL have its req ignored at the edge ending that cycle, so a held req is never issued twice.
REQ-023 Both pending, DBG_PRIORITY=0 -> the requester that did not win last time SHALL win; a single pending requester SHALL always win.
REQ-024 Both pending, DBG_PRIORITY=1 -> debug SHALL win.
REQ-025 Request latency SHALL be 1 cycle: req sampled at edge T -> the first access cycle is T+1.
REQ-026 Addresses and data SHALL be latched at acceptance; later input changes SHALL be ignored.
REQ-027 CPU_LO SHALL drive rf_we=1 and rf_wdata=cpu_wdata[7:0]; for byte writes rf_addr=cpu_addr, for word writes rf_addr={cpu_addr[4:1],0}.
REQ-028 After CPU_LO: byte -> cpu_gnt=1 in CPU_LO; word -> go to CPU_HI.
REQ-029 CPU_HI SHALL drive rf_we=1, rf_addr={cpu_addr[4:1],1}, rf_wdata=cpu_wdata[15:8] and cpu_gnt=1.
REQ-030 A word write SHALL be atomic: no debug access may be placed between CPU_LO and CPU_HI.
REQ-031 An odd cpu_addr with cpu_word=1 SHALL be forced even; there is no wrap past r31.
REQ-032 DBG_WR SHALL drive rf_we=1, rf_addr=dbg_addr, rf_wdata=dbg_wdata and dbg_ack=1.
REQ-033 DBG_RD SHALL drive rf_we=0, rf_addr=dbg_addr, dbg_ack=1 and dbg_rdata=rf_rdata, so read data is returned in the same cycle.
REQ-034 In IDLE: rf_we=0, rf_addr=0, rf_wdata=0, both gnt/ack outputs 0.
REQ-035 At most one of cpu_gnt or dbg_ack SHALL be 1 in any cycle.

Reset
REQ-036 rst_n low SHALL immediately force state=IDLE and all outputs to 0, and set the round-robin last-winner per RESET_LAST_DBG.
REQ-037 Reset in CPU_LO of a word write SHALL leave the high byte unwritten and SHALL NOT pulse gnt; the requester reissues.
REQ-038 Leaving reset, the first acceptance SHALL occur at the first rising edge with rst_n high.

Structure
REQ-039 Package avr_rf_pkg SHALL hold the FSM state type and constants RF_ADDR_W=5 and RF_DATA_W=8, shared with the register file and the debugger.
REQ-040 Two-requester round-robin selection SHALL be sub-module rr_arbiter2 (inputs req[1:0] and priority-mode; output one-hot grant; internal last-winner register).

Verification
REQ-041 CPU byte write, cpu_addr=5, data=0x00A7 -> next cycle rf_we=1, rf_addr=5, rf_wdata=A7, cpu_gnt=1.
REQ-042 CPU word write, addr=25 (odd), data=0xBEEF -> r24<=EF then r25<=BE on consecutive cycles; cpu_gnt only on the second cycle.
REQ-043 Word write and debug read both held -> debug read waits until CPU_HI completes; dbg_rdata equals r24 afterwards.
REQ-044 Both held continuously with DBG_PRIORITY=0 -> grants alternate CPU, DBG, CPU, DBG; no gnt/ack overlap; no request is granted twice.
REQ-045 DBG_PRIORITY=1 with both held -> debug wins every arbitration.
REQ-046 rst_n pulsed low during CPU_LO of a word write -> outputs 0 asynchronously, r(n+1) unchanged, no cpu_gnt; the reissued request completes normally.

Source files
------------

// File: rtl/avr_rf_pkg.sv
// Shared register-file definitions for the AVR core, the debugger and the
// register-file arbiter.
//   RF_ADDR_W  : register index width (r0..r31)
//   RF_DATA_W  : register width
//   CPU_DATA_W : CPU write-data width, wide enough for a register pair
//   state_t    : arbiter FSM state encoding
package avr_rf_pkg;
  localparam int RF_ADDR_W  = 5;
  localparam int RF_DATA_W  = 8;
  localparam int CPU_DATA_W = 2 * RF_DATA_W;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    CPU_LO = 3'd1,
    CPU_HI = 3'd2,
    DBG_WR = 3'd3,
    DBG_RD = 3'd4
  } state_t;
endpackage

// File: rtl/regfile_arbiter_if.sv
// Bundle of the CPU request, debugger request and register-file port-1
// signals around the register-file arbiter.
//   slave  : arbiter side (takes requests and rf_rdata, drives grants/rf port)
//   master : environment side (CPU, debugger and register file)
//
// Handshake: a requester raises *_req with its fields and keeps them stable
// until it sees the one-cycle cpu_gnt / dbg_ack pulse marking completion.
// dbg_rdata is meaningful only while dbg_ack=1 for a read and is 0 otherwise.
interface regfile_arbiter_if;
  logic                               cpu_req;
  logic [avr_rf_pkg::RF_ADDR_W-1:0]   cpu_addr;
  logic [avr_rf_pkg::CPU_DATA_W-1:0]  cpu_wdata;
  logic                               cpu_word;
  logic                               cpu_gnt;
  logic                               dbg_req;
  logic                               dbg_we;
  logic [avr_rf_pkg::RF_ADDR_W-1:0]   dbg_addr;
  logic [avr_rf_pkg::RF_DATA_W-1:0]   dbg_wdata;
  logic                               dbg_ack;
  logic [avr_rf_pkg::RF_DATA_W-1:0]   dbg_rdata;
  logic                               rf_we;
  logic [avr_rf_pkg::RF_ADDR_W-1:0]   rf_addr;
  logic [avr_rf_pkg::RF_DATA_W-1:0]   rf_wdata;
  logic [avr_rf_pkg::RF_DATA_W-1:0]   rf_rdata;

  modport slave (
    input  cpu_req, cpu_addr, cpu_wdata, cpu_word,
    input  dbg_req, dbg_we, dbg_addr, dbg_wdata,
    input  rf_rdata,
    output cpu_gnt, dbg_ack, dbg_rdata,
    output rf_we, rf_addr, rf_wdata
  );

  modport master (
    output cpu_req, cpu_addr, cpu_wdata, cpu_word,
    output dbg_req, dbg_we, dbg_addr, dbg_wdata,
    output rf_rdata,
    input  cpu_gnt, dbg_ack, dbg_rdata,
    input  rf_we, rf_addr, rf_wdata
  );
endinterface

// File: rtl/rr_arbiter2.sv
// Two-requester arbiter, bit 0 = CPU, bit 1 = debugger.
//   clk, rst_n : clock, asynchronous active-low reset
//   req[1:0]   : pending requests (already masked by the caller)
//   prio_mode  : 1 = debugger always wins a tie, 0 = round-robin
//   gnt[1:0]   : one-hot grant, combinational from req and last winner
// The last-winner register advances whenever a grant is given.
module rr_arbiter2 #(
  parameter bit RESET_LAST_DBG = 1'b1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] req,
  input  logic       prio_mode,
  output logic [1:0] gnt
);
  logic last_dbg_q;
  logic last_dbg_d;

  always_comb begin
    gnt        = 2'b00;
    last_dbg_d = last_dbg_q;
    case (req)
      2'b01:   gnt = 2'b01;
      2'b10:   gnt = 2'b10;
      // Tie: debugger wins if forced, or if the CPU won last time.
      2'b11:   gnt = (prio_mode || !last_dbg_q) ? 2'b10 : 2'b01;
      default: gnt = 2'b00;
    endcase
    if (gnt != 2'b00) last_dbg_d = gnt[1];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) last_dbg_q <= RESET_LAST_DBG;
    else        last_dbg_q <= last_dbg_d;
  end
endmodule

// File: rtl/regfile_arbiter.sv
// Shares register-file port 1 between CPU writes (byte or register-pair)
// and debugger reads/writes, one register access per cycle.
//   clk, rst_n : clock, asynchronous active-low reset
//   bus        : request/grant and register-file signals (slave side)
//   fsm_state  : current FSM state, for observation
// A request is taken at the edge ending IDLE or the last cycle of an access;
// the requester being completed in that cycle is masked so a held request is
// not issued twice. A pair write occupies CPU_LO then CPU_HI back to back,
// with no acceptance between them, which keeps it atomic.
module regfile_arbiter
  import avr_rf_pkg::*;
#(
  parameter bit DBG_PRIORITY   = 1'b0,
  parameter bit RESET_LAST_DBG = 1'b1
) (
  input  logic                clk,
  input  logic                rst_n,
  regfile_arbiter_if.slave    bus,
  output state_t              fsm_state
);
  state_t                  state_q, state_d;
  logic [RF_ADDR_W-1:0]    cpu_addr_q, cpu_addr_d;
  logic [CPU_DATA_W-1:0]   cpu_wdata_q, cpu_wdata_d;
  logic                    cpu_word_q, cpu_word_d;
  logic [RF_ADDR_W-1:0]    dbg_addr_q, dbg_addr_d;
  logic [RF_DATA_W-1:0]    dbg_wdata_q, dbg_wdata_d;
  logic                    rf_we_q, rf_we_d;
  logic [RF_ADDR_W-1:0]    rf_addr_q, rf_addr_d;
  logic [RF_DATA_W-1:0]    rf_wdata_q, rf_wdata_d;
  logic                    cpu_gnt_q, cpu_gnt_d;
  logic                    dbg_ack_q, dbg_ack_d;

  logic       cpu_final, dbg_final, accept;
  logic [1:0] arb_req, arb_gnt;

  assign cpu_final = (state_q == CPU_LO && !cpu_word_q) || (state_q == CPU_HI);
  assign dbg_final = (state_q == DBG_WR) || (state_q == DBG_RD);
  assign accept    = !(state_q == CPU_LO && cpu_word_q);
  assign arb_req   = {bus.dbg_req && !dbg_final, bus.cpu_req && !cpu_final}
                     & {2{accept}};

  rr_arbiter2 #(.RESET_LAST_DBG(RESET_LAST_DBG)) u_rr (
    .clk       (clk),
    .rst_n     (rst_n),
    .req       (arb_req),
    .prio_mode (DBG_PRIORITY),
    .gnt       (arb_gnt)
  );

  always_comb begin
    state_d     = state_q;
    cpu_addr_d  = cpu_addr_q;
    cpu_wdata_d = cpu_wdata_q;
    cpu_word_d  = cpu_word_q;
    dbg_addr_d  = dbg_addr_q;
    dbg_wdata_d = dbg_wdata_q;
    rf_we_d     = 1'b0;
    rf_addr_d   = '0;
    rf_wdata_d  = '0;
    cpu_gnt_d   = 1'b0;
    dbg_ack_d   = 1'b0;

    if (!accept) begin
      state_d = CPU_HI;
    end else if (arb_gnt[0]) begin
      state_d     = CPU_LO;
      cpu_addr_d  = bus.cpu_addr;
      cpu_wdata_d = bus.cpu_wdata;
      cpu_word_d  = bus.cpu_word;
    end else if (arb_gnt[1]) begin
      state_d     = bus.dbg_we ? DBG_WR : DBG_RD;
      dbg_addr_d  = bus.dbg_addr;
      dbg_wdata_d = bus.dbg_wdata;
    end else begin
      state_d = IDLE;
    end

    // Outputs are registered, so they are decoded from the next state.
    case (state_d)
      CPU_LO: begin
        rf_we_d    = 1'b1;
        rf_addr_d  = cpu_word_d ? {cpu_addr_d[RF_ADDR_W-1:1], 1'b0} : cpu_addr_d;
        rf_wdata_d = cpu_wdata_d[RF_DATA_W-1:0];
        cpu_gnt_d  = !cpu_word_d;
      end
      CPU_HI: begin
        rf_we_d    = 1'b1;
        rf_addr_d  = {cpu_addr_d[RF_ADDR_W-1:1], 1'b1};
        rf_wdata_d = cpu_wdata_d[CPU_DATA_W-1:RF_DATA_W];
        cpu_gnt_d  = 1'b1;
      end
      DBG_WR: begin
        rf_we_d    = 1'b1;
        rf_addr_d  = dbg_addr_d;
        rf_wdata_d = dbg_wdata_d;
        dbg_ack_d  = 1'b1;
      end
      DBG_RD: begin
        rf_addr_d  = dbg_addr_d;
        dbg_ack_d  = 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      cpu_addr_q  <= '0;
      cpu_wdata_q <= '0;
      cpu_word_q  <= 1'b0;
      dbg_addr_q  <= '0;
      dbg_wdata_q <= '0;
      rf_we_q     <= 1'b0;
      rf_addr_q   <= '0;
      rf_wdata_q  <= '0;
      cpu_gnt_q   <= 1'b0;
      dbg_ack_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      cpu_addr_q  <= cpu_addr_d;
      cpu_wdata_q <= cpu_wdata_d;
      cpu_word_q  <= cpu_word_d;
      dbg_addr_q  <= dbg_addr_d;
      dbg_wdata_q <= dbg_wdata_d;
      rf_we_q     <= rf_we_d;
      rf_addr_q   <= rf_addr_d;
      rf_wdata_q  <= rf_wdata_d;
      cpu_gnt_q   <= cpu_gnt_d;
      dbg_ack_q   <= dbg_ack_d;
    end
  end

  assign bus.rf_we     = rf_we_q;
  assign bus.rf_addr   = rf_addr_q;
  assign bus.rf_wdata  = rf_wdata_q;
  assign bus.cpu_gnt   = cpu_gnt_q;
  assign bus.dbg_ack   = dbg_ack_q;
  // Read data passes straight through in the DBG_RD cycle.
  assign bus.dbg_rdata = (state_q == DBG_RD) ? bus.rf_rdata : '0;
  assign fsm_state     = state_q;
endmodule
